// File: rtl/mult_result_checker.sv
// Scores a multiplier under test: recomputes each product with a shift-add unit and accumulates error statistics.
// Latency: a triple accepted at edge T0 reports at edge T0+WIDTH+1; throughput is one triple per WIDTH+2 cycles.
// Backpressure: in_ready is high only in IDLE with clear low. Optional macro MULT_CHK_MAXERR_EN enables err_max tracking.
module mult_result_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2*WIDTH-1:0]       in_p,
    output logic                     res_valid,
    output logic                     res_match,
    output logic [2*WIDTH-1:0]       res_exp,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [2*WIDTH+CNT_W-1:0] err_sum,
    output logic [2*WIDTH-1:0]       err_max
);

    localparam int PW  = 2 * WIDTH;
    localparam int SW  = PW + CNT_W;
    localparam int BCW = $clog2(WIDTH + 1);

    localparam logic [BCW-1:0] CNT_INIT = BCW'(WIDTH);
    localparam logic [BCW-1:0] CNT_ONE  = BCW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;

    logic [1:0]       r_state;
    logic [PW-1:0]    r_a;      // operand A, pre-shifted so it always sits at weight WIDTH-counter
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]    r_p;
    logic [PW-1:0]    r_acc;
    logic [BCW-1:0]   r_cnt;

    logic [PW-1:0]    w_diff;
    logic [SW:0]      w_sum_ext;
    logic [SW-1:0]    w_sum_next;
    logic [CNT_W-1:0] w_smp_next;
    logic [CNT_W-1:0] w_err_next;
    logic             w_accept;

    // A triple offered together with clear is refused so it cannot slip past an abort.
    assign in_ready = (r_state == S_IDLE) && !clear;
    assign w_accept = in_valid && in_ready;

    // Absolute error and saturating statistic increments, consumed only in CMP.
    always_comb begin
        w_diff     = (r_p >= r_acc) ? (r_p - r_acc) : (r_acc - r_p);
        w_sum_ext  = {1'b0, err_sum} + {{(CNT_W + 1){1'b0}}, w_diff};
        w_sum_next = w_sum_ext[SW] ? {SW{1'b1}} : w_sum_ext[SW-1:0];
        w_smp_next = (&sample_cnt) ? sample_cnt : sample_cnt + 1'b1;
        w_err_next = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
    end

    // Sequencer and shift-add datapath; clear outranks any state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (clear) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= {{WIDTH{1'b0}}, in_a};
                        r_b     <= in_b;
                        r_p     <= in_p;
                        r_acc   <= '0;
                        r_cnt   <= CNT_INIT;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (r_b[0]) begin
                        r_acc <= r_acc + r_a;
                    end
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result and statistic registers; they move only on CMP, clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_match  <= 1'b0;
            res_exp    <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            err_sum    <= '0;
        end else if (clear) begin
            res_valid  <= 1'b0;
            res_match  <= 1'b0;
            res_exp    <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            err_sum    <= '0;
        end else begin
            res_valid <= 1'b0;
            if (r_state == S_CMP) begin
                res_valid  <= 1'b1;
                res_match  <= (w_diff == '0);
                res_exp    <= r_acc;
                sample_cnt <= w_smp_next;
                if (w_diff != '0) begin
                    err_cnt <= w_err_next;
                end
                err_sum <= w_sum_next;
            end
        end
    end

`ifdef MULT_CHK_MAXERR_EN
    logic [PW-1:0] r_max;

    // Running maximum of the absolute error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
        end else if (clear) begin
            r_max <= '0;
        end else if ((r_state == S_CMP) && (w_diff > r_max)) begin
            r_max <= w_diff;
        end
    end

    assign err_max = r_max;
`else
    assign err_max = '0;
`endif

endmodule
